// File: rtl/trace_pkg.sv
// Shared types for the trace request issuer: opcodes, FSM states, default entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trace_pkg;

  localparam int TIME_W_DEF = 32;
  localparam int ADDR_W_DEF = 33;
  localparam int ERR_MAX    = 255;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } trace_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_DONE
  } issuer_state_e;

  // Default-width entry; the issuer builds its own entry type from its parameters.
  typedef struct packed {
    logic [TIME_W_DEF-1:0] issue_time;
    trace_op_e             op;
    logic [ADDR_W_DEF-1:0] addr;
  } trace_entry_t;

endpackage

// File: rtl/trace_request_issuer_if.sv
// Loader push port and downstream request port of the trace request issuer.
// Latency: n/a (wiring only).
// Backpressure: ld_ready gates the loader, req_ready gates the issuer.
interface trace_request_issuer_if #(
  parameter int TIME_W = 32,
  parameter int ADDR_W = 33
);

  logic              ld_valid;
  logic              ld_ready;
  logic [TIME_W-1:0] ld_time;
  logic [1:0]        ld_op;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_last;

  logic              req_valid;
  logic              req_ready;
  logic [TIME_W-1:0] req_time;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;

  // Environment side: the loader pushing entries and the request consumer.
  modport master (
    output ld_valid, ld_time, ld_op, ld_addr, ld_last, req_ready,
    input  ld_ready, req_valid, req_time, req_op, req_addr
  );

  // Issuer side.
  modport slave (
    input  ld_valid, ld_time, ld_op, ld_addr, ld_last, req_ready,
    output ld_ready, req_valid, req_time, req_op, req_addr
  );

endinterface

// File: rtl/trace_fifo.sv
// Generic DEPTH-entry FIFO of trace entries with registered full/empty flags.
// Latency: a pushed entry is visible at dout the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_nxt, rd_nxt;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointers; the extra MSB distinguishes full from empty.
  always_comb begin
    wr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
    rd_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointers and registered flags derived from the next-state pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
    end
  end

  assign dout      = mem[rd_ptr[AW-1:0]];
  assign occupancy = wr_ptr - rd_ptr;

endmodule

// File: rtl/trace_request_issuer.sv
// Buffers timed trace entries and issues each one once the CPU cycle counter reaches its time.
// Latency: an already-due entry pushed at edge k is presented after edge k+1; at most 1 issue per 2 cycles.
// Backpressure: ld_ready = !full; a presented request is held until req_ready.
module trace_request_issuer
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIME_W  = TIME_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit SKIP_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   idle_in,
  trace_request_issuer_if.slave  bus,
  output logic [TIME_W-1:0]      cycle_cnt,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [7:0]             err_cnt,
  output logic                   done
);

  typedef struct packed {
    logic [TIME_W-1:0] issue_time;
    trace_op_e         op;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  issuer_state_e     state_q, state_d;
  entry_t            ld_entry, head, req_q;
  logic              fifo_full, fifo_empty;
  logic              push, drop, wr, pop, due, skip, last_seen;
  logic [TIME_W-1:0] last_time;
  logic [TIME_W:0]   cnt_inc;

  assign ld_entry = '{issue_time: bus.ld_time, op: trace_op_e'(bus.ld_op), addr: bus.ld_addr};

  // Out-of-order or illegal entries are consumed but never stored.
  assign push = bus.ld_valid & bus.ld_ready;
  assign drop = (trace_op_e'(bus.ld_op) == OP_ILLEGAL) || (bus.ld_time < last_time);
  assign wr   = push & ~drop;

  assign cnt_inc = {1'b0, cycle_cnt} + {{TIME_W{1'b0}}, 1'b1};
  assign due     = (head.issue_time <= cycle_cnt);
  // Jump straight to the head's time when downstream is idle and nothing is due soon.
  assign skip    = SKIP_EN && en && idle_in && (state_q == ST_WAIT) && !fifo_empty &&
                   ({1'b0, head.issue_time} > cnt_inc);

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr),
    .pop       (pop),
    .din       (ld_entry),
    .dout      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  // Issue FSM next state; pop moves the head into the output register.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty || wr)    state_d = ST_WAIT;
        else if (last_seen)       state_d = ST_DONE;
      end
      ST_WAIT: begin
        if (fifo_empty)           state_d = ST_IDLE;
        else if (en && due) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.req_ready) begin
          if (!fifo_empty || wr)  state_d = ST_WAIT;
          else if (last_seen)     state_d = ST_DONE;
          else                    state_d = ST_IDLE;
        end
      end
      ST_DONE:                    state_d = ST_DONE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Held request fields; stable for the whole ISSUE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   req_q <= '0;
    else if (pop) req_q <= head;
  end

  // CPU cycle counter: frozen by en, saturates at all-ones, may fast-forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (en) begin
      if (skip)              cycle_cnt <= head.issue_time;
      else if (!(&cycle_cnt)) cycle_cnt <= cnt_inc[TIME_W-1:0];
    end
  end

  // Push-side bookkeeping: ordering watermark, saturating drop count, end-of-trace flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_time <= '0;
      err_cnt   <= '0;
      last_seen <= 1'b0;
    end else begin
      if (wr) last_time <= bus.ld_time;
      if (push && drop && (err_cnt != 8'(ERR_MAX))) err_cnt <= err_cnt + 8'd1;
      if (push && bus.ld_last) last_seen <= 1'b1;
    end
  end

  assign bus.ld_ready  = ~fifo_full;
  assign bus.req_valid = (state_q == ST_ISSUE);
  assign bus.req_time  = req_q.issue_time;
  assign bus.req_op    = req_q.op;
  assign bus.req_addr  = req_q.addr;
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_trace_request_issuer.sv
// Directed bench for the trace request issuer; drives and samples on the falling clock edge.
// Latency: n/a.
// Backpressure: req_ready driven per scenario.
module tb_trace_request_issuer;

  localparam int DEPTH  = 16;
  localparam int TIME_W = 32;
  localparam int ADDR_W = 33;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              en    = 1'b0;
  logic              idle_in = 1'b0;
  logic [TIME_W-1:0] cycle_cnt;
  logic [4:0]        occupancy;
  logic [7:0]        err_cnt;
  logic              done;

  int n_pass  = 0;
  int n_total = 0;

  trace_request_issuer_if #(.TIME_W(TIME_W), .ADDR_W(ADDR_W)) bus ();

  trace_request_issuer #(
    .DEPTH   (DEPTH),
    .TIME_W  (TIME_W),
    .ADDR_W  (ADDR_W),
    .SKIP_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .idle_in   (idle_in),
    .bus       (bus),
    .cycle_cnt (cycle_cnt),
    .occupancy (occupancy),
    .err_cnt   (err_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic idle_bus();
    bus.ld_valid  = 1'b0;
    bus.ld_time   = '0;
    bus.ld_op     = 2'd0;
    bus.ld_addr   = '0;
    bus.ld_last   = 1'b0;
    bus.req_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    idle_in = 1'b0;
    idle_bus();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One-cycle push issued from a falling edge; returns on the next falling edge.
  task automatic push(input logic [31:0] t, input logic [1:0] op, input logic [32:0] addr,
                      input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_time  = t;
    bus.ld_op    = op;
    bus.ld_addr  = addr;
    bus.ld_last  = last;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (bus.req_valid !== 1'b0) $display("FAIL rst_req_valid got %0d want 0", bus.req_valid); else n_pass++;
    n_total++; if (bus.ld_ready !== 1'b1) $display("FAIL rst_ld_ready got %0d want 1", bus.ld_ready); else n_pass++;
    n_total++; if (cycle_cnt !== 32'd0) $display("FAIL rst_cycle_cnt got %0d want 0", cycle_cnt); else n_pass++;
    n_total++; if (occupancy !== 5'd0) $display("FAIL rst_occupancy got %0d want 0", occupancy); else n_pass++;
    n_total++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done got %0d want 0", done); else n_pass++;
    n_total++; if (bus.req_addr !== 33'd0) $display("FAIL rst_req_addr got %0h want 0", bus.req_addr); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] exp_t [3] = '{32'd5, 32'd5, 32'd9};
    logic [1:0]  exp_o [3] = '{2'd0, 2'd1, 2'd2};
    logic [32:0] exp_a [3] = '{33'h1_0000_0000, 33'h40, 33'h80};
    logic [31:0] exp_c [3] = '{32'd6, 32'd8, 32'd10};
    int idx = 0;
    do_reset();
    push(5, 2'd0, 33'h1_0000_0000, 1'b0);
    push(5, 2'd1, 33'h40, 1'b0);
    push(9, 2'd2, 33'h80, 1'b1);
    n_total++; if (occupancy !== 5'd3) $display("FAIL basic_occ got %0d want 3", occupancy); else n_pass++;
    en = 1'b1;
    bus.req_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      @(negedge clk);
      if (bus.req_valid) begin
        n_total++; if (bus.req_time !== exp_t[idx]) $display("FAIL basic_time[%0d] got %0d want %0d", idx, bus.req_time, exp_t[idx]); else n_pass++;
        n_total++; if (bus.req_op !== exp_o[idx]) $display("FAIL basic_op[%0d] got %0d want %0d", idx, bus.req_op, exp_o[idx]); else n_pass++;
        n_total++; if (bus.req_addr !== exp_a[idx]) $display("FAIL basic_addr[%0d] got %0h want %0h", idx, bus.req_addr, exp_a[idx]); else n_pass++;
        n_total++; if (cycle_cnt !== exp_c[idx]) $display("FAIL basic_cnt[%0d] got %0d want %0d", idx, cycle_cnt, exp_c[idx]); else n_pass++;
        idx++;
      end
    end
    n_total++; if (idx !== 3) $display("FAIL basic_issue_count got %0d want 3", idx); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b1) $display("FAIL basic_done got %0d want 1", done); else n_pass++;
    bus.req_ready = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    en = 1'b1;
    push(0, 2'd0, 33'h11, 1'b0);
    n_total++; if (bus.req_valid !== 1'b0) $display("FAIL lat_valid_k got %0d want 0", bus.req_valid); else n_pass++;
    n_total++; if (occupancy !== 5'd1) $display("FAIL lat_occ_k got %0d want 1", occupancy); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.req_valid !== 1'b1) $display("FAIL lat_valid_k1 got %0d want 1", bus.req_valid); else n_pass++;
    n_total++; if (bus.req_addr !== 33'h11) $display("FAIL lat_addr got %0h want 11", bus.req_addr); else n_pass++;
    bus.req_ready = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_valid !== 1'b0) $display("FAIL lat_retire got %0d want 0", bus.req_valid); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL lat_done got %0d want 0", done); else n_pass++;
    bus.req_ready = 1'b0;
  endtask

  task automatic test_fast_forward();
    do_reset();
    idle_in = 1'b1;
    push(1000, 2'd0, 33'h2000, 1'b0);
    en = 1'b1;
    @(negedge clk);
    n_total++; if (cycle_cnt !== 32'd1000) $display("FAIL ff_jump got %0d want 1000", cycle_cnt); else n_pass++;
    n_total++; if (bus.req_valid !== 1'b0) $display("FAIL ff_valid_early got %0d want 0", bus.req_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.req_valid !== 1'b1) $display("FAIL ff_valid got %0d want 1", bus.req_valid); else n_pass++;
    n_total++; if (bus.req_time !== 32'd1000) $display("FAIL ff_time got %0d want 1000", bus.req_time); else n_pass++;
    n_total++; if (cycle_cnt !== 32'd1001) $display("FAIL ff_cnt_after got %0d want 1001", cycle_cnt); else n_pass++;
    idle_in = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(i, 2'd0, 33'(i), 1'b0);
    n_total++; if (occupancy !== 5'd16) $display("FAIL full_occ got %0d want 16", occupancy); else n_pass++;
    n_total++; if (bus.ld_ready !== 1'b0) $display("FAIL full_ld_ready got %0d want 0", bus.ld_ready); else n_pass++;
    bus.ld_valid = 1'b1;
    bus.ld_time  = 32'd100;
    bus.ld_addr  = 33'h100;
    @(negedge clk);
    n_total++; if (occupancy !== 5'd16) $display("FAIL full_refuse_occ got %0d want 16", occupancy); else n_pass++;
    en = 1'b1;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    n_total++; if (occupancy !== 5'd15) $display("FAIL full_pushpop_occ got %0d want 15", occupancy); else n_pass++;
    n_total++; if (bus.ld_ready !== 1'b1) $display("FAIL full_ld_ready_free got %0d want 1", bus.ld_ready); else n_pass++;
    n_total++; if (bus.req_valid !== 1'b1 || bus.req_time !== 32'd0) $display("FAIL full_head_issue got valid=%0d time=%0d want valid=1 time=0", bus.req_valid, bus.req_time); else n_pass++;
    n_total++; if (err_cnt !== 8'd0) $display("FAIL full_err_cnt got %0d want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_errors();
    int n_req = 0;
    do_reset();
    push(0, 2'd3, 33'h0, 1'b0);
    push(20, 2'd0, 33'h20, 1'b0);
    push(10, 2'd0, 33'h10, 1'b1);
    n_total++; if (err_cnt !== 8'd2) $display("FAIL err_cnt got %0d want 2", err_cnt); else n_pass++;
    n_total++; if (occupancy !== 5'd1) $display("FAIL err_occ got %0d want 1", occupancy); else n_pass++;
    en = 1'b1;
    bus.req_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.req_valid) begin
        n_req++;
        n_total++; if (bus.req_time !== 32'd20) $display("FAIL err_req_time got %0d want 20", bus.req_time); else n_pass++;
      end
    end
    n_total++; if (n_req !== 1) $display("FAIL err_req_count got %0d want 1", n_req); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL err_done got %0d want 1", done); else n_pass++;
    bus.req_ready = 1'b0;
  endtask

  task automatic test_en_freeze();
    logic seen = 1'b0;
    do_reset();
    push(2, 2'd1, 33'h123, 1'b0);
    en = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.req_valid) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b1) $display("FAIL frz_issue_seen got %0d want 1", seen); else n_pass++;
    n_total++; if (cycle_cnt !== 32'd3) $display("FAIL frz_issue_cnt got %0d want 3", cycle_cnt); else n_pass++;
    en = 1'b0;
    repeat (5) @(negedge clk);
    n_total++; if (bus.req_valid !== 1'b1) $display("FAIL frz_valid got %0d want 1", bus.req_valid); else n_pass++;
    n_total++; if (bus.req_time !== 32'd2) $display("FAIL frz_time got %0d want 2", bus.req_time); else n_pass++;
    n_total++; if (bus.req_op !== 2'd1) $display("FAIL frz_op got %0d want 1", bus.req_op); else n_pass++;
    n_total++; if (bus.req_addr !== 33'h123) $display("FAIL frz_addr got %0h want 123", bus.req_addr); else n_pass++;
    n_total++; if (cycle_cnt !== 32'd3) $display("FAIL frz_cnt got %0d want 3", cycle_cnt); else n_pass++;
    en = 1'b1;
    bus.req_ready = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_valid !== 1'b0) $display("FAIL frz_retire got %0d want 0", bus.req_valid); else n_pass++;
    n_total++; if (cycle_cnt !== 32'd4) $display("FAIL frz_cnt_resume got %0d want 4", cycle_cnt); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL frz_done got %0d want 0", done); else n_pass++;
    bus.req_ready = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    int n_req = 0;
    do_reset();
    for (int i = 0; i < 5; i++) push(i, 2'd0, 33'h100 + 33'(i), 1'b0);
    en = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_valid !== 1'b1) $display("FAIL mid_valid got %0d want 1", bus.req_valid); else n_pass++;
    n_total++; if (occupancy !== 5'd4) $display("FAIL mid_occ got %0d want 4", occupancy); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.req_valid !== 1'b0) $display("FAIL mid_rst_valid got %0d want 0", bus.req_valid); else n_pass++;
    n_total++; if (occupancy !== 5'd0) $display("FAIL mid_rst_occ got %0d want 0", occupancy); else n_pass++;
    n_total++; if (bus.ld_ready !== 1'b1) $display("FAIL mid_rst_ld_ready got %0d want 1", bus.ld_ready); else n_pass++;
    n_total++; if (cycle_cnt !== 32'd0) $display("FAIL mid_rst_cnt got %0d want 0", cycle_cnt); else n_pass++;
    n_total++; if (bus.req_addr !== 33'd0) $display("FAIL mid_rst_addr got %0h want 0", bus.req_addr); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req_valid) n_req++;
    end
    n_total++; if (n_req !== 0) $display("FAIL mid_post_reqs got %0d want 0", n_req); else n_pass++;
    bus.req_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_fast_forward();
    test_full();
    test_errors();
    test_en_freeze();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trace_request_issuer.md
Name: trace_request_issuer

Overview:
- Synthesizable, parametrised successor to the file-driven trace parser.
- Buffers trace entries {time, op, addr} pushed by a loader (testbench file reader or memory-mapped loader) in a DEPTH-entry FIFO.
- Keeps a free-running CPU cycle counter and releases each entry on a valid/ready request port once the counter reaches the entry's time.
- Sits between the trace loader and the memory-controller request queue; fast-forwards time when the controller is idle.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- TIME_W, 32, width of the trace time and cycle counter.
- ADDR_W, 33, request address width.
- SKIP_EN, 1, 1 enables idle fast-forward of the cycle counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- en  in  1  enables counting and issue; 0 freezes time.
- ld_valid  in  1  loader entry valid.
- ld_ready  out  1  loader may push; equals !full.
- ld_time  in  TIME_W  entry issue time in CPU cycles.
- ld_op  in  2  0=read, 1=write, 2=ifetch, 3=illegal.
- ld_addr  in  ADDR_W  entry address.
- ld_last  in  1  marks the final trace entry.
- idle_in  in  1  downstream request queue empty.
- req_valid  out  1  request presented.
- req_ready  in  1  downstream accepts.
- req_time, req_op, req_addr  out  TIME_W/2/ADDR_W  presented entry fields.
- cycle_cnt  out  TIME_W  current CPU cycle.
- occupancy  out  $clog2(DEPTH)+1  FIFO fill level.
- err_cnt  out  8  dropped-entry count; saturates at 255.
- done  out  1  trace fully issued; sticky.

Behaviour:
- Reset: all outputs 0 (ld_ready=1), FIFO empty, FSM in IDLE, last_time=0.
- Push: a push occurs when ld_valid & ld_ready.
  - ld_op==3, or ld_time < last_time: entry is accepted but dropped, and err_cnt increments.
  - Otherwise the entry is written and last_time is updated.
  - ld_last is recorded even on a dropped entry.
- FIFO: pointers carry an extra wrap bit. full/empty are registered.
  - Simultaneous push and pop while full: the pop completes; the push is refused because ld_ready was 0.
  - Simultaneous push and pop otherwise: occupancy is unchanged.
- cycle_cnt: increments by 1 per cycle while en=1. Saturates at all-ones and never wraps.
- Fast-forward: applies when SKIP_EN & en & idle_in & FSM==WAIT & head.time > cycle_cnt+1. In that case cycle_cnt <= head.time on the next edge instead of incrementing.
- FSM:
  - IDLE: FIFO empty. Go to WAIT when non-empty.
  - WAIT: head not yet due. Go to ISSUE on the edge where en & head.time <= cycle_cnt.
    - On that edge the head is popped into the output register and req_valid becomes 1.
  - ISSUE: req_valid=1 and req_* held stable, including while en=0.
    - On req_valid & req_ready the entry retires; go to WAIT if non-empty, else IDLE, or DONE if last was seen.
    - req_valid drops for at least one cycle between requests, giving a maximum of 1 issue per 2 cycles.
  - DONE: entered when last is recorded and the FIFO is empty with no request pending. done=1 and the FSM holds until reset.
- Latency: an entry pushed at edge k with time already due gives req_valid high after edge k+1.
- Reset mid-ISSUE: req_valid drops immediately (asynchronous). The pending entry is lost.

Decomposition:
- Package trace_pkg holds:
  - enum trace_op_e {OP_READ, OP_WRITE, OP_IFETCH, OP_ILLEGAL};
  - struct trace_entry_t {time, op, addr}, parametrised through package localparams TIME_W_DEF and ADDR_W_DEF;
  - localparam ERR_MAX = 255.
- Sub-module trace_fifo: generic DEPTH x trace_entry_t FIFO with push/pop/full/empty/occupancy.
- The issuer top holds the FSM, cycle counter, validation and output register.

Test Plan:
- Push 3 entries {t=5,R,0x1_0000_0000},{t=5,W,0x40},{t=9,F,0x80}, req_ready=1, SKIP_EN=0 -> issues at cycle_cnt>=5, 5 (after a 1-cycle gap), and >=9; done=1 afterward.
- Push t=1000, idle_in=1, SKIP_EN=1 -> cycle_cnt jumps to 1000 and req_valid rises the following cycle.
- Fill 16 entries with req_ready=0 -> ld_ready=0 and occupancy=16. A 17th push is refused. One accept frees a slot and ld_ready=1 next cycle.
- Push op=3, then t=20 followed by t=10 -> err_cnt=2; only the t=20 entry issues.
- Assert en=0 during ISSUE with req_ready=0 -> req_valid and req_* stay stable and cycle_cnt frozen; after en=1 and req_ready=1 the entry retires.
- Assert rst_n=0 mid-ISSUE with 4 entries queued -> outputs return to reset values immediately, occupancy=0, and no requests follow.
